mbist_repair_cam: RTL and testbench
===================================

Name: mbist_repair_cam

Overview:
- Parametrised successor to the MBIST address-repair logic: a small CAM of failing addresses with valid bits, duplicate suppression, overflow detection and a bidirectional scan chain.
- Logs failing addresses reported by the MBIST FSM and remaps functional/BIST accesses to spare rows.
- Scan chain supports capture (read-out) and update (restore from fuse/ATE), so repair survives power cycles.
- Sits between the MBIST controller/functional mux and the SRAM address pin.

Parameters:
- BIST_ADDR_WD, 9, SRAM address width.
- BIST_ERR_LIMIT, 4, number of spare rows / CAM entries (1..16).
- BIST_REPAIR_ADDR_START, 9'h1FC, address of spare row 0; entry i maps to START+i.
- ENTRY_WD, BIST_ADDR_WD+1, scan bits per entry ({valid, addr}).
- CHAIN_LEN, BIST_ERR_LIMIT*ENTRY_WD, total scan-chain length.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- Error  in  1  failure strobe from MBIST compare
- ErrorAddr  in  BIST_ADDR_WD  failing address, valid with Error
- clear  in  1  synchronous clear of all entries and flags
- AddressIn  in  BIST_ADDR_WD  requested address
- AddressOut  out  BIST_ADDR_WD  remapped address (combinational)
- Correct  out  1  repairable: at least one entry and no overflow
- repair_full  out  1  all entries valid
- repair_fail  out  1  sticky overflow: unrepairable
- err_cnt  out  $clog2(BIST_ERR_LIMIT+1)  valid-entry count
- scan_capture  in  1  load table into shift register
- scan_shift  in  1  shift one bit per clk
- scan_update  in  1  load shift register into table
- sdi  in  1  scan data in
- sdo  out  1  scan data out
- scan_done  out  1  one-cycle pulse after CHAIN_LEN shifts

Behaviour:
- Reset: all valid bits 0, err_cnt=0, Correct=0, repair_full=0, repair_fail=0, shift register 0, shift counter 0, scan_done=0, sdo=0.
- Logging, per clk with Error=1:
  - ErrorAddr matches a valid entry: no change (duplicate suppressed).
  - Else err_cnt<BIST_ERR_LIMIT: write entry[err_cnt]={1,ErrorAddr}, err_cnt+1.
  - Else: repair_fail<=1 (sticky until clear or reset).
- Correct registered: 1 when err_cnt>0 and repair_fail=0. repair_full = (err_cnt==BIST_ERR_LIMIT).
- Remap: AddressOut = BIST_REPAIR_ADDR_START+i for the lowest i with valid[i] and addr[i]==AddressIn, else AddressIn. Zero latency; a new entry takes effect the cycle after Error.
- Scan FSM states:
  - IDLE: default.
  - scan_capture -> CAPT: one cycle; shift register <= table with entry0 at LSB, bits {addr LSB.., valid MSB} per entry; counter cleared.
  - scan_shift -> SHIFT: shift right, sdi into MSB, sdo=bit0, counter+1. At counter==CHAIN_LEN-1, pulse scan_done and counter wraps to 0. scan_shift low -> IDLE with counter held.
  - scan_update -> UPD: one cycle; table <= shift register; err_cnt <= popcount(valid); repair_fail<=0.
- Priority when simultaneous: clear > scan_update > scan_capture > scan_shift > Error. A lower-priority Error in that cycle is dropped and repair_fail is not set.
- Entries restored by update may be non-contiguous. The next Error writes the lowest invalid slot, not index err_cnt.
- Reset mid-shift: chain contents and counter lost; table is cleared.

Decomposition:
- mbist_pkg holds: BIST_ERR_LIMIT default, typedef repair_entry_t {logic valid; logic [BIST_ADDR_WD-1:0] addr;}, scan-state enum {IDLE, CAPT, SHIFT, UPD}.
- One sub-module, mbist_repair_scan_chain: shift register, counter, FSM, scan_done. CAM, logging and remap stay in the top.

Test Plan (BIST_ERR_LIMIT=4, BIST_ADDR_WD=9, BIST_REPAIR_ADDR_START=0x1FC):
- Error with ErrorAddr=0x010 -> next cycle err_cnt=1, Correct=1; AddressIn=0x010 gives 0x1FC; AddressIn=0x011 gives 0x011.
- Error 0x010 on three consecutive cycles -> err_cnt=1, only entry0 valid, repair_fail=0.
- Errors 0x001,0x002,0x003,0x004,0x005 -> err_cnt=4, repair_full=1, repair_fail=1, Correct=0; 0x004 maps to 0x1FF; 0x005 unmapped.
- After entries {0x001,0x002}: capture, then 40 shifts -> sdo=1,0,0,0,0,0,0,0,0,1 (entry0 LSB first, valid last), then entry1; scan_done pulses on the 40th shift.
- Shift in image with only entry2={1,0x0AA}, then update -> err_cnt=1; 0x0AA maps to 0x1FE; next Error 0x033 writes entry0 (maps to 0x1FC).
- Assert rst_n low after 15 shifts -> all outputs at reset values; 0x0AA unmapped.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types for the MBIST repair CAM and its scan chain.
// Entry layout matches the scan image: {valid, addr}.
package mbist_pkg;

  localparam int MBIST_ADDR_WD   = 9;
  localparam int MBIST_ERR_LIMIT = 4;
  localparam logic [MBIST_ADDR_WD-1:0] MBIST_REPAIR_START = 9'h1FC;

  typedef struct packed {
    logic                     valid;
    logic [MBIST_ADDR_WD-1:0] addr;
  } repair_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    SHIFT,
    UPD
  } scan_state_e;

endpackage

// File: rtl/mbist_repair_scan_chain.sv
// Capture/shift/update scan register for the repair table.
// Operations act on the edge where their strobe is sampled.
module mbist_repair_scan_chain
  import mbist_pkg::*;
#(
  parameter int CHAIN_LEN = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 scan_capture,
  input  logic                 scan_shift,
  input  logic                 scan_update,
  input  logic                 sdi,
  input  logic [CHAIN_LEN-1:0] tbl_i,
  output logic [CHAIN_LEN-1:0] sr_o,
  output logic                 upd_o,
  output logic                 sdo,
  output logic                 scan_done
);

  localparam int CNT_W = $clog2(CHAIN_LEN);

  scan_state_e          state_q, state_d;
  logic [CHAIN_LEN-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    priority case (1'b1)
      clear:        state_d = IDLE;
      scan_update:  state_d = UPD;
      scan_capture: state_d = CAPT;
      scan_shift:   state_d = SHIFT;
      default:      state_d = IDLE;
    endcase
  end

  assign wrap = (cnt_q == CNT_W'(CHAIN_LEN - 1));

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    upd_o  = 1'b0;
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else begin
      unique case (state_d)
        CAPT: begin
          sr_d  = tbl_i;
          cnt_d = '0;
        end
        SHIFT: begin
          sr_d   = {sdi, sr_q[CHAIN_LEN-1:1]};
          cnt_d  = wrap ? '0 : cnt_q + 1'b1;
          done_d = wrap;
        end
        UPD:     upd_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign sr_o      = sr_q;
  assign sdo       = sr_q[0];
  assign scan_done = done_q && (state_q == SHIFT);

endmodule

// File: rtl/mbist_repair_cam.sv
// Failing-address CAM with spare-row remap, overflow tracking
// and a scan chain for saving/restoring the repair table.
module mbist_repair_cam
  import mbist_pkg::*;
#(
  parameter int BIST_ADDR_WD = MBIST_ADDR_WD,
  parameter int BIST_ERR_LIMIT = MBIST_ERR_LIMIT,
  parameter logic [BIST_ADDR_WD-1:0] BIST_REPAIR_ADDR_START = MBIST_REPAIR_START,
  parameter int ENTRY_WD = BIST_ADDR_WD + 1,
  parameter int CHAIN_LEN = BIST_ERR_LIMIT * ENTRY_WD,
  parameter int CW = $clog2(BIST_ERR_LIMIT + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    Error,
  input  logic [BIST_ADDR_WD-1:0] ErrorAddr,
  input  logic                    clear,
  input  logic [BIST_ADDR_WD-1:0] AddressIn,
  output logic [BIST_ADDR_WD-1:0] AddressOut,
  output logic                    Correct,
  output logic                    repair_full,
  output logic                    repair_fail,
  output logic [CW-1:0]           err_cnt,
  input  logic                    scan_capture,
  input  logic                    scan_shift,
  input  logic                    scan_update,
  input  logic                    sdi,
  output logic                    sdo,
  output logic                    scan_done
);

  localparam int N  = BIST_ERR_LIMIT;
  localparam int AW = BIST_ADDR_WD;

  logic [N-1:0]         valid_q, valid_d;
  logic [N-1:0][AW-1:0] addr_q, addr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 fail_q, fail_d;
  logic                 correct_q, correct_d;

  logic [CHAIN_LEN-1:0] tbl, sr;
  logic                 upd;
  logic                 hit, free_ok;
  int                   free_idx;
  logic [CW-1:0]        pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      fail_q    <= 1'b0;
      correct_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      fail_q    <= fail_d;
      correct_q <= correct_d;
    end
  end

  always_comb begin
    tbl = '0;
    for (int i = 0; i < N; i++)
      tbl[i*ENTRY_WD +: ENTRY_WD] = {valid_q[i], addr_q[i]};
  end

  mbist_repair_scan_chain #(
    .CHAIN_LEN(CHAIN_LEN)
  ) u_chain (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .scan_capture(scan_capture),
    .scan_shift  (scan_shift),
    .scan_update (scan_update),
    .sdi         (sdi),
    .tbl_i       (tbl),
    .sr_o        (sr),
    .upd_o       (upd),
    .sdo         (sdo),
    .scan_done   (scan_done)
  );

  // Restored tables may have holes, so allocate the lowest free slot.
  always_comb begin
    hit      = 1'b0;
    free_ok  = 1'b0;
    free_idx = 0;
    pop      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid_q[i] && addr_q[i] == ErrorAddr) hit = 1'b1;
      if (!valid_q[i]) begin
        free_ok  = 1'b1;
        free_idx = i;
      end
      pop = pop + CW'(sr[i*ENTRY_WD + AW]);
    end
  end

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    if (clear) begin
      valid_d = '0;
      addr_d  = '0;
      cnt_d   = '0;
      fail_d  = 1'b0;
    end else if (upd) begin
      for (int i = 0; i < N; i++) begin
        valid_d[i] = sr[i*ENTRY_WD + AW];
        addr_d[i]  = sr[i*ENTRY_WD +: AW];
      end
      cnt_d  = pop;
      fail_d = 1'b0;
    end else if (Error && !scan_capture && !scan_shift && !hit) begin
      if (free_ok) begin
        valid_d[free_idx] = 1'b1;
        addr_d[free_idx]  = ErrorAddr;
        cnt_d             = cnt_q + 1'b1;
      end else begin
        fail_d = 1'b1;
      end
    end
    correct_d = (cnt_d != '0) && !fail_d;
  end

  always_comb begin
    AddressOut = AddressIn;
    for (int i = N - 1; i >= 0; i--)
      if (valid_q[i] && addr_q[i] == AddressIn)
        AddressOut = BIST_REPAIR_ADDR_START + AW'(i);
  end

  assign err_cnt     = cnt_q;
  assign Correct     = correct_q;
  assign repair_fail = fail_q;
  assign repair_full = (cnt_q == CW'(N));

endmodule

// File: tb/tb_mbist_repair_cam.sv
// Directed bench for mbist_repair_cam: logging, remap, overflow,
// scan capture/shift/update and reset during shifting.
module tb_mbist_repair_cam;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Error;
  logic [8:0] ErrorAddr;
  logic       clear;
  logic [8:0] AddressIn;
  logic [8:0] AddressOut;
  logic       Correct;
  logic       repair_full;
  logic       repair_fail;
  logic [2:0] err_cnt;
  logic       scan_capture;
  logic       scan_shift;
  logic       scan_update;
  logic       sdi;
  logic       sdo;
  logic       scan_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mbist_repair_cam dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Error       (Error),
    .ErrorAddr   (ErrorAddr),
    .clear       (clear),
    .AddressIn   (AddressIn),
    .AddressOut  (AddressOut),
    .Correct     (Correct),
    .repair_full (repair_full),
    .repair_fail (repair_fail),
    .err_cnt     (err_cnt),
    .scan_capture(scan_capture),
    .scan_shift  (scan_shift),
    .scan_update (scan_update),
    .sdi         (sdi),
    .sdo         (sdo),
    .scan_done   (scan_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic log_err(input logic [8:0] a);
    Error = 1'b1;
    ErrorAddr = a;
    tick();
    Error = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    AddressIn = 9'h010;
    #3;
    n_cmp++;
    if ({err_cnt, Correct, repair_full, repair_fail, sdo, scan_done} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_flags got cnt=%0d c=%b f=%b x=%b sdo=%b d=%b want all 0",
               err_cnt, Correct, repair_full, repair_fail, sdo, scan_done);
    end
    n_cmp++;
    if (AddressOut !== 9'h010) begin
      n_bad++;
      $display("FAIL reset_remap got %h want 010", AddressOut);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_log();
    log_err(9'h010);
    n_cmp++;
    if (err_cnt !== 3'd1 || Correct !== 1'b1) begin
      n_bad++;
      $display("FAIL log_first got cnt=%0d c=%b want 1 1", err_cnt, Correct);
    end
    AddressIn = 9'h010;
    #1;
    n_cmp++;
    if (AddressOut !== 9'h1FC) begin
      n_bad++;
      $display("FAIL log_remap_hit got %h want 1fc", AddressOut);
    end
    AddressIn = 9'h011;
    #1;
    n_cmp++;
    if (AddressOut !== 9'h011) begin
      n_bad++;
      $display("FAIL log_remap_miss got %h want 011", AddressOut);
    end
  endtask

  task automatic test_dup();
    log_err(9'h010);
    log_err(9'h010);
    log_err(9'h010);
    n_cmp++;
    if (err_cnt !== 3'd1 || repair_fail !== 1'b0 || Correct !== 1'b1) begin
      n_bad++;
      $display("FAIL dup got cnt=%0d x=%b c=%b want 1 0 1",
               err_cnt, repair_fail, Correct);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    n_cmp++;
    if (err_cnt !== 3'd0 || Correct !== 1'b0) begin
      n_bad++;
      $display("FAIL clear got cnt=%0d c=%b want 0 0", err_cnt, Correct);
    end
    log_err(9'h001);
    log_err(9'h002);
    log_err(9'h003);
    log_err(9'h004);
    n_cmp++;
    if (repair_full !== 1'b1 || repair_fail !== 1'b0 || Correct !== 1'b1) begin
      n_bad++;
      $display("FAIL full got f=%b x=%b c=%b want 1 0 1",
               repair_full, repair_fail, Correct);
    end
    log_err(9'h005);
    n_cmp++;
    if ({err_cnt, repair_full, repair_fail, Correct} !== 6'b100110) begin
      n_bad++;
      $display("FAIL overflow got cnt=%0d f=%b x=%b c=%b want 4 1 1 0",
               err_cnt, repair_full, repair_fail, Correct);
    end
    AddressIn = 9'h004;
    #1;
    n_cmp++;
    if (AddressOut !== 9'h1FF) begin
      n_bad++;
      $display("FAIL ovf_remap4 got %h want 1ff", AddressOut);
    end
    AddressIn = 9'h005;
    #1;
    n_cmp++;
    if (AddressOut !== 9'h005) begin
      n_bad++;
      $display("FAIL ovf_remap5 got %h want 005", AddressOut);
    end
    log_err(9'h006);
    n_cmp++;
    if (repair_fail !== 1'b1 || err_cnt !== 3'd4) begin
      n_bad++;
      $display("FAIL ovf_sticky got x=%b cnt=%0d want 1 4", repair_fail, err_cnt);
    end
  endtask

  task automatic test_capture_shift();
    logic [39:0] img;
    img = {20'h0, 10'h202, 10'h201};
    do_clear();
    log_err(9'h001);
    log_err(9'h002);
    scan_capture = 1'b1;
    tick();
    scan_capture = 1'b0;
    n_cmp++;
    if (sdo !== img[0]) begin
      n_bad++;
      $display("FAIL capt_bit0 got %b want %b", sdo, img[0]);
    end
    scan_shift = 1'b1;
    for (int k = 1; k < 40; k++) begin
      tick();
      n_cmp++;
      if (sdo !== img[k] || scan_done !== 1'b0) begin
        n_bad++;
        $display("FAIL shift_bit%0d got sdo=%b done=%b want %b 0",
                 k, sdo, scan_done, img[k]);
      end
    end
    tick();
    scan_shift = 1'b0;
    n_cmp++;
    if (scan_done !== 1'b1) begin
      n_bad++;
      $display("FAIL shift_done got %b want 1", scan_done);
    end
    tick();
    n_cmp++;
    if (scan_done !== 1'b0) begin
      n_bad++;
      $display("FAIL shift_done_pulse got %b want 0", scan_done);
    end
  endtask

  task automatic test_update();
    logic [39:0] img;
    img = {10'h0, 10'h2AA, 20'h0};
    do_clear();
    scan_shift = 1'b1;
    for (int k = 0; k < 40; k++) begin
      sdi = img[k];
      tick();
    end
    scan_shift = 1'b0;
    sdi = 1'b0;
    n_cmp++;
    if (scan_done !== 1'b1) begin
      n_bad++;
      $display("FAIL upd_shift_done got %b want 1", scan_done);
    end
    scan_update = 1'b1;
    tick();
    scan_update = 1'b0;
    n_cmp++;
    if ({err_cnt, repair_fail, Correct, repair_full} !== 6'b001010) begin
      n_bad++;
      $display("FAIL upd_flags got cnt=%0d x=%b c=%b f=%b want 1 0 1 0",
               err_cnt, repair_fail, Correct, repair_full);
    end
    AddressIn = 9'h0AA;
    #1;
    n_cmp++;
    if (AddressOut !== 9'h1FE) begin
      n_bad++;
      $display("FAIL upd_remap got %h want 1fe", AddressOut);
    end
    AddressIn = 9'h001;
    #1;
    n_cmp++;
    if (AddressOut !== 9'h001) begin
      n_bad++;
      $display("FAIL upd_old_gone got %h want 001", AddressOut);
    end
    log_err(9'h033);
    AddressIn = 9'h033;
    #1;
    n_cmp++;
    if (err_cnt !== 3'd2 || AddressOut !== 9'h1FC) begin
      n_bad++;
      $display("FAIL upd_hole_fill got cnt=%0d out=%h want 2 1fc",
               err_cnt, AddressOut);
    end
  endtask

  task automatic test_priority();
    Error = 1'b1;
    ErrorAddr = 9'h044;
    scan_capture = 1'b1;
    tick();
    Error = 1'b0;
    scan_capture = 1'b0;
    AddressIn = 9'h044;
    #1;
    n_cmp++;
    if (err_cnt !== 3'd2 || AddressOut !== 9'h044) begin
      n_bad++;
      $display("FAIL prio_drop got cnt=%0d out=%h want 2 044", err_cnt, AddressOut);
    end
  endtask

  task automatic test_reset_mid_shift();
    scan_capture = 1'b1;
    tick();
    scan_capture = 1'b0;
    scan_shift = 1'b1;
    sdi = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    rst_n = 1'b0;
    #1;
    scan_shift = 1'b0;
    sdi = 1'b0;
    AddressIn = 9'h0AA;
    #1;
    n_cmp++;
    if ({err_cnt, Correct, repair_full, repair_fail, sdo, scan_done} !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_mid_flags got cnt=%0d c=%b f=%b x=%b sdo=%b d=%b want all 0",
               err_cnt, Correct, repair_full, repair_fail, sdo, scan_done);
    end
    n_cmp++;
    if (AddressOut !== 9'h0AA) begin
      n_bad++;
      $display("FAIL rst_mid_remap got %h want 0aa", AddressOut);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    Error = 1'b0;
    ErrorAddr = '0;
    clear = 1'b0;
    AddressIn = '0;
    scan_capture = 1'b0;
    scan_shift = 1'b0;
    scan_update = 1'b0;
    sdi = 1'b0;
    test_reset();
    test_log();
    test_dup();
    test_overflow();
    test_capture_shift();
    test_update();
    test_priority();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
